dead_time_monitor: RTL and testbench
====================================

Name: dead_time_monitor

Overview:
- Receive-side counterpart of the dead-time generator. It observes the complementary gate pair pwmout_A/pwmout_B after polarity, measures the dead time actually present at each commutation, and flags commutations that are shorter than the required minimum and any shoot-through.
- It also recovers the underlying PWM command.
- It sits beside each dead-time channel, fed from the gate outputs or their pin loopback.

Parameters:
- DTCOUNT_WIDTH, default 10: width of the dead-time counters, minimum-time inputs and measured values (cycles of clk).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; asserted when 0.
- gate_A  input  1  observed gate A level, as driven.
- gate_B  input  1  observed gate B level, as driven.
- logic_A  input  1  polarity of A; active_A = gate_A ^ ~logic_A.
- logic_B  input  1  polarity of B; active_B = gate_B ^ ~logic_B.
- dtmin_A  input  DTCOUNT_WIDTH  minimum dead time required before A turns on.
- dtmin_B  input  DTCOUNT_WIDTH  minimum dead time required before B turns on.
- clear  input  1  one-cycle pulse that clears the sticky flags.
- pwm_rec  output  1  recovered PWM: 1 while A is on, 0 while B is on, holds its value during dead time.
- dt_meas_A  output  DTCOUNT_WIDTH  last measured dead time before A turned on.
- dt_meas_B  output  DTCOUNT_WIDTH  last measured dead time before B turned on.
- dt_valid_A  output  1  one-cycle pulse when dt_meas_A updates.
- dt_valid_B  output  1  one-cycle pulse when dt_meas_B updates.
- dt_err_A  output  1  sticky: a measured A dead time was below dtmin_A.
- dt_err_B  output  1  sticky: a measured B dead time was below dtmin_B.
- shoot_through  output  1  sticky: A and B were both active in the same sample.

Behaviour:
- Input stage: active_A and active_B are registered once into sA/sB. The FSM and all outputs are registered. Latency from a gate edge to the FSM/output response is 2 clk cycles.
- Reset (reset==0 at posedge): state=IDLE, counter=0, every output 0.
- FSM states, evaluated on sA/sB:
  - IDLE: (1,0)->A_ON, pwm_rec=1. (0,1)->B_ON, pwm_rec=0. (1,1)->FAULT. (0,0)->stay. No measurement is taken on the exit from IDLE.
  - A_ON: (0,0)->DT_AB, counter=1. (0,1)->B_ON, direct commutation, see below. (1,1)->FAULT. (1,0)->stay.
  - B_ON: mirror of A_ON; (0,0)->DT_BA, counter=1.
  - DT_AB:
    - (0,0): counter increments, saturating at 2^W-1 (no wrap).
    - (0,1): dt_meas_B=counter, dt_valid_B=1, dt_err_B set if counter<dtmin_B, next state B_ON, pwm_rec=0.
    - (1,0): return to A_ON; no measurement and no valid pulse (pulse dropped without commutation).
    - (1,1): FAULT.
  - DT_BA: mirror of DT_AB, producing dt_meas_A/dt_valid_A/dt_err_A.
  - Direct commutation (A_ON sees (0,1), or B_ON sees (1,0)): measurement is 0, the valid pulse is issued, and the error is set if dtmin>0.
  - FAULT: entered from any state on (1,1); shoot_through=1. Stays while any input is active. Exits to IDLE on (0,0). pwm_rec holds its value.
- Measured value = number of consecutive (0,0) samples between the turn-off and the turn-on.
- Sticky flags clear on clear=1. If a set condition and clear coincide, set wins.
- dtmin_A and dtmin_B are sampled at the compare cycle; they may change at any time.
- A reset mid-dead-time discards the measurement in progress; no valid pulse is issued.

Optional Feature:
- Macro DTMON_INSYNC_EN.
- Defined: gate_A/gate_B pass through a two-flop synchronizer ahead of the polarity/sample register, for asynchronous pin loopback. Input-to-output latency becomes 4 cycles. The synchronizer flops reset to 0.
- Undefined: single sample register only; latency 2 cycles. All other behaviour is identical.

Test Plan:
- Polarity logic_A=logic_B=1, dtmin_B=5. Hold A on 10 cycles, then both off 7 cycles, then B on -> dt_meas_B=7, one dt_valid_B pulse 2 cycles after B rises, dt_err_B=0, pwm_rec 1->0.
- Same sequence with 3 off cycles and dtmin_A=5 on the B->A edge -> dt_meas_A=3, dt_err_A=1 and it stays set. clear pulse -> dt_err_A=0.
- Direct commutation: A falls and B rises in the same cycle, dtmin_B=2 -> dt_meas_B=0, dt_valid_B pulse, dt_err_B=1.
- Overlap of 2 cycles with A=B=1 -> shoot_through=1, no valid pulse. Then both off -> IDLE. Then A on -> pwm_rec=1, no measurement.
- DTCOUNT_WIDTH=4, both off 40 cycles, then A on -> dt_meas_A=15 (saturated). A re-asserts during DT_AB -> no valid pulse.
- Drive reset=0 mid-DT_AB for 1 cycle -> all outputs 0, state IDLE, no dt_valid on the subsequent B turn-on. Repeat with logic_A=logic_B=0 (inverted gates) for identical results.

Source files
------------

// File: rtl/dead_time_monitor.sv
// dead_time_monitor: measures dead time between a complementary gate pair, flags short gaps and shoot-through.
// Define DTMON_INSYNC_EN to add a two-flop synchronizer on gate_A/gate_B for asynchronous loopback.
module dead_time_monitor #(
    parameter int DTCOUNT_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gate_A,
    input  logic                     gate_B,
    input  logic                     logic_A,
    input  logic                     logic_B,
    input  logic [DTCOUNT_WIDTH-1:0] dtmin_A,
    input  logic [DTCOUNT_WIDTH-1:0] dtmin_B,
    input  logic                     clear,
    output logic                     pwm_rec,
    output logic [DTCOUNT_WIDTH-1:0] dt_meas_A,
    output logic [DTCOUNT_WIDTH-1:0] dt_meas_B,
    output logic                     dt_valid_A,
    output logic                     dt_valid_B,
    output logic                     dt_err_A,
    output logic                     dt_err_B,
    output logic                     shoot_through
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] A_ON  = 3'd1;
    localparam logic [2:0] B_ON  = 3'd2;
    localparam logic [2:0] DT_AB = 3'd3;
    localparam logic [2:0] DT_BA = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    localparam logic [DTCOUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DTCOUNT_WIDTH-1:0] CNT_ONE = DTCOUNT_WIDTH'(1);

    logic [2:0]               state;
    logic [DTCOUNT_WIDTH-1:0] counter;
    logic                     in_a;
    logic                     in_b;
    logic                     sa;
    logic                     sb;

`ifdef DTMON_INSYNC_EN
    logic [1:0] sync_a;
    logic [1:0] sync_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= {sync_a[0], gate_A};
            sync_b <= {sync_b[0], gate_B};
        end
    end

    assign in_a = sync_a[1];
    assign in_b = sync_b[1];
`else
    assign in_a = gate_A;
    assign in_b = gate_B;
`endif

    // Polarity is folded in at the sample register so the FSM sees "active" levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sa <= 1'b0;
            sb <= 1'b0;
        end else begin
            sa <= in_a ^ ~logic_A;
            sb <= in_b ^ ~logic_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            counter       <= '0;
            pwm_rec       <= 1'b0;
            dt_meas_A     <= '0;
            dt_meas_B     <= '0;
            dt_valid_A    <= 1'b0;
            dt_valid_B    <= 1'b0;
            dt_err_A      <= 1'b0;
            dt_err_B      <= 1'b0;
            shoot_through <= 1'b0;
        end else begin
            dt_valid_A <= 1'b0;
            dt_valid_B <= 1'b0;
            // Clear first so a coincident set below takes priority.
            if (clear) begin
                dt_err_A      <= 1'b0;
                dt_err_B      <= 1'b0;
                shoot_through <= 1'b0;
            end
            if (sa && sb) begin
                state         <= FAULT;
                shoot_through <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (sa) begin
                            state   <= A_ON;
                            pwm_rec <= 1'b1;
                        end else if (sb) begin
                            state   <= B_ON;
                            pwm_rec <= 1'b0;
                        end
                    end
                    A_ON: begin
                        if (!sa && !sb) begin
                            state   <= DT_AB;
                            counter <= CNT_ONE;
                        end else if (sb) begin
                            state      <= B_ON;
                            pwm_rec    <= 1'b0;
                            dt_meas_B  <= '0;
                            dt_valid_B <= 1'b1;
                            if (dtmin_B != '0) dt_err_B <= 1'b1;
                        end
                    end
                    B_ON: begin
                        if (!sa && !sb) begin
                            state   <= DT_BA;
                            counter <= CNT_ONE;
                        end else if (sa) begin
                            state      <= A_ON;
                            pwm_rec    <= 1'b1;
                            dt_meas_A  <= '0;
                            dt_valid_A <= 1'b1;
                            if (dtmin_A != '0) dt_err_A <= 1'b1;
                        end
                    end
                    DT_AB: begin
                        if (sb) begin
                            state      <= B_ON;
                            pwm_rec    <= 1'b0;
                            dt_meas_B  <= counter;
                            dt_valid_B <= 1'b1;
                            if (counter < dtmin_B) dt_err_B <= 1'b1;
                        end else if (sa) begin
                            state <= A_ON;
                        end else if (counter != CNT_MAX) begin
                            counter <= counter + 1'b1;
                        end
                    end
                    DT_BA: begin
                        if (sa) begin
                            state      <= A_ON;
                            pwm_rec    <= 1'b1;
                            dt_meas_A  <= counter;
                            dt_valid_A <= 1'b1;
                            if (counter < dtmin_A) dt_err_A <= 1'b1;
                        end else if (sb) begin
                            state <= B_ON;
                        end else if (counter != CNT_MAX) begin
                            counter <= counter + 1'b1;
                        end
                    end
                    FAULT: begin
                        if (!sa && !sb) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dead_time_monitor.sv
// tb_dead_time_monitor: directed and randomized stimulus checked each cycle
// against a commutation-level reference model of the dead-time monitor.
module tb_dead_time_monitor;

    localparam int W   = 4;
    localparam int SAT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         gate_A = 1'b0;
    logic         gate_B = 1'b0;
    logic         logic_A = 1'b1;
    logic         logic_B = 1'b1;
    logic         clear = 1'b0;
    logic [W-1:0] dtmin_A = '0;
    logic [W-1:0] dtmin_B = '0;
    logic         pwm_rec;
    logic [W-1:0] dt_meas_A;
    logic [W-1:0] dt_meas_B;
    logic         dt_valid_A;
    logic         dt_valid_B;
    logic         dt_err_A;
    logic         dt_err_B;
    logic         shoot_through;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: which side owns the bridge and how long it has been off.
    int m_owner = 0;
    bit m_fault = 0;
    int m_gap = -1;
    bit m_pwm = 0;
    int m_meas_a = 0;
    int m_meas_b = 0;
    bit m_va = 0, m_vb = 0, m_ea = 0, m_eb = 0, m_st = 0;

    bit a1 = 0, b1 = 0, a2 = 0, b2 = 0;
    bit r_prev = 0;

    dead_time_monitor #(.DTCOUNT_WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .gate_A(gate_A),
        .gate_B(gate_B),
        .logic_A(logic_A),
        .logic_B(logic_B),
        .dtmin_A(dtmin_A),
        .dtmin_B(dtmin_B),
        .clear(clear),
        .pwm_rec(pwm_rec),
        .dt_meas_A(dt_meas_A),
        .dt_meas_B(dt_meas_B),
        .dt_valid_A(dt_valid_A),
        .dt_valid_B(dt_valid_B),
        .dt_err_A(dt_err_A),
        .dt_err_B(dt_err_B),
        .shoot_through(shoot_through)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = 0; m_fault = 0; m_gap = -1; m_pwm = 0;
        m_meas_a = 0; m_meas_b = 0;
        m_va = 0; m_vb = 0; m_ea = 0; m_eb = 0; m_st = 0;
    endtask

    task automatic model_sample(input bit pa, input bit pb, input bit c, input int dma, input int dmb);
        int meas;
        m_va = 0;
        m_vb = 0;
        if (c) begin
            m_ea = 0; m_eb = 0; m_st = 0;
        end
        if (pa && pb) begin
            m_st = 1; m_fault = 1; m_gap = -1;
        end else if (m_fault) begin
            if (!pa && !pb) begin
                m_fault = 0; m_owner = 0;
            end
        end else if (pa) begin
            if (m_owner == 2) begin
                meas = (m_gap < 0) ? 0 : ((m_gap > SAT) ? SAT : m_gap);
                m_meas_a = meas; m_va = 1;
                if (meas < dma) m_ea = 1;
            end
            m_owner = 1; m_pwm = 1; m_gap = -1;
        end else if (pb) begin
            if (m_owner == 1) begin
                meas = (m_gap < 0) ? 0 : ((m_gap > SAT) ? SAT : m_gap);
                m_meas_b = meas; m_vb = 1;
                if (meas < dmb) m_eb = 1;
            end
            m_owner = 2; m_pwm = 0; m_gap = -1;
        end else if (m_owner != 0) begin
            m_gap = (m_gap < 0) ? 1 : m_gap + 1;
        end
    endtask

    // a/b are active levels; r is the reset level presented at the next edge.
    task automatic step(input bit a, input bit b, input bit c = 0, input bit r = 1);
        bit r_now, c_now;
        int dma, dmb;
        logic [15:0] exp_v, act_v;
        r_now = reset; c_now = clear;
        dma = int'(dtmin_A); dmb = int'(dtmin_B);
        @(posedge clk);
        #1;
        gate_A = logic_A ? a : !a;
        gate_B = logic_B ? b : !b;
        clear = c;
        reset = r;
        @(negedge clk);
        cyc = cyc + 1;
        if (!r_now) model_reset();
        else model_sample(r_prev ? a2 : 1'b0, r_prev ? b2 : 1'b0, c_now, dma, dmb);
        r_prev = r_now;
        a2 = a1; b2 = b1; a1 = a; b1 = b;
        exp_v = {2'b00, m_pwm, W'(m_meas_a), W'(m_meas_b), m_va, m_vb, m_ea, m_eb, m_st};
        act_v = {2'b00, pwm_rec, dt_meas_A, dt_meas_B, dt_valid_A, dt_valid_B,
                 dt_err_A, dt_err_B, shoot_through};
        chk($sformatf("cyc%0d_outputs", cyc), act_v, exp_v);
    endtask

    task automatic set_pol(input logic la, input logic lb);
        logic_A = la;
        logic_B = lb;
        gate_A = la ? a1 : !a1;
        gate_B = lb ? b1 : !b1;
    endtask

    task automatic reset_mid_dt(input string tag);
        repeat (3) step(0, 0, 0, 0);
        repeat (4) step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0, 0, 0);
        step(0, 0);
        chk({tag, "_rst_all_zero"},
            {2'b00, pwm_rec, dt_meas_A, dt_meas_B, dt_valid_A, dt_valid_B,
             dt_err_A, dt_err_B, shoot_through}, 16'h0000);
        repeat (2) step(0, 0);
        step(0, 1);
        step(0, 1);
        chk({tag, "_no_valid_b"}, 16'(dt_valid_B), 16'd0);
        step(0, 1);
        chk({tag, "_no_valid_b2"}, 16'(dt_valid_B), 16'd0);
        chk({tag, "_meas_b_zero"}, 16'(dt_meas_B), 16'd0);
    endtask

    initial begin
        int sel, len;
        bit ra, rb;

        repeat (3) step(0, 0, 0, 0);
        chk("reset_pwm", 16'(pwm_rec), 16'd0);
        chk("reset_st", 16'(shoot_through), 16'd0);
        repeat (2) step(0, 0);

        dtmin_B = W'(5);
        repeat (10) step(1, 0);
        repeat (7) step(0, 0);
        step(0, 1);
        step(0, 1);
        chk("ab_valid_early", 16'(dt_valid_B), 16'd0);
        step(0, 1);
        chk("ab_valid", 16'(dt_valid_B), 16'd1);
        chk("ab_meas7", 16'(dt_meas_B), 16'd7);
        chk("ab_err0", 16'(dt_err_B), 16'd0);
        chk("ab_pwm0", 16'(pwm_rec), 16'd0);
        step(0, 1);
        chk("ab_pulse_once", 16'(dt_valid_B), 16'd0);

        dtmin_A = W'(5);
        repeat (3) step(0, 1);
        repeat (3) step(0, 0);
        repeat (3) step(1, 0);
        chk("ba_meas3", 16'(dt_meas_A), 16'd3);
        chk("ba_err1", 16'(dt_err_A), 16'd1);
        repeat (3) step(1, 0);
        chk("ba_err_sticky", 16'(dt_err_A), 16'd1);
        step(1, 0, 1);
        step(1, 0);
        chk("ba_err_cleared", 16'(dt_err_A), 16'd0);

        dtmin_B = W'(2);
        repeat (3) step(0, 1);
        chk("direct_meas0", 16'(dt_meas_B), 16'd0);
        chk("direct_valid", 16'(dt_valid_B), 16'd1);
        chk("direct_err", 16'(dt_err_B), 16'd1);

        repeat (2) step(1, 1);
        repeat (3) step(0, 0);
        chk("overlap_st", 16'(shoot_through), 16'd1);
        repeat (2) step(1, 0);
        chk("after_fault_no_valid", 16'(dt_valid_A), 16'd0);
        step(1, 0);
        chk("after_fault_pwm1", 16'(pwm_rec), 16'd1);

        repeat (3) step(0, 1);
        repeat (40) step(0, 0);
        repeat (3) step(1, 0);
        chk("sat_meas15", 16'(dt_meas_A), 16'd15);
        repeat (2) step(0, 0);
        repeat (2) step(1, 0);
        step(1, 0);
        chk("drop_no_valid_b", 16'(dt_valid_B), 16'd0);

        reset_mid_dt("pol1");
        step(0, 0, 0, 0);
        set_pol(1'b0, 1'b0);
        reset_mid_dt("pol0");

        set_pol(1'b1, 1'b0);
        for (int seg = 0; seg < 80; seg++) begin
            sel = int'($urandom_range(0, 9));
            ra = (sel >= 4 && sel < 7) || sel == 9;
            rb = (sel >= 7);
            len = int'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) dtmin_A = W'($urandom_range(0, SAT));
            if ($urandom_range(0, 3) == 0) dtmin_B = W'($urandom_range(0, SAT));
            for (int i = 0; i < len; i++)
                step(ra, rb, $urandom_range(0, 30) == 0, $urandom_range(0, 150) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
